// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller: tick width, lamp codes
// and the phase state encoding.
package tlc_pkg;

  localparam int unsigned TICK_W = 7;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5
`ifdef TLC_PED_EN
    ,PED_WALK = 3'd6
`endif
  } state_t;

endpackage

// File: rtl/tick_detect.sv
// Double-registers the upstream tenths count and flags any change as a tick.
module tick_detect
  import tlc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [TICK_W-1:0] ten_sec,
  output logic              tick
);

  logic [TICK_W-1:0] s1;
  logic [TICK_W-1:0] s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ten_sec;
      s2 <= s1;
    end
  end

  assign tick = (s1 != s2);

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road phase sequencer stepped by tenths-count ticks.
// Optional pedestrian walk phase enabled by defining TLC_PED_EN.
module traffic_light_fsm
  import tlc_pkg::*;
#(
  parameter int unsigned GREEN_T  = 80,
  parameter int unsigned YELLOW_T = 20,
  parameter int unsigned ALLRED_T = 10,
  parameter int unsigned WALK_T   = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TICK_W-1:0] ten_sec,
  input  logic              ped_req,
  output logic [2:0]        ns_light,
  output logic [2:0]        ew_light,
  output logic              walk,
  output logic [TICK_W-1:0] phase_remaining
);

  localparam logic [TICK_W-1:0] GREEN_D  = TICK_W'(GREEN_T);
  localparam logic [TICK_W-1:0] YELLOW_D = TICK_W'(YELLOW_T);
  localparam logic [TICK_W-1:0] ALLRED_D = TICK_W'(ALLRED_T);

  state_t            state, state_nxt, advance;
  logic [TICK_W-1:0] elapsed, elapsed_nxt, cur_dur;
  logic              tick;
  logic              illegal;

  tick_detect u_tick_detect (
    .clk     (clk),
    .reset   (reset),
    .ten_sec (ten_sec),
    .tick    (tick)
  );

`ifdef TLC_PED_EN
  localparam logic [TICK_W-1:0] WALK_D = TICK_W'(WALK_T);
  logic ped_pending, ped_pending_nxt;
  logic next_ns, next_ns_nxt;
  logic enter_walk;
`else
  logic unused_ped;
  assign unused_ped = ped_req ^ (WALK_T == 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= NS_GREEN;
      elapsed <= '0;
`ifdef TLC_PED_EN
      ped_pending <= 1'b0;
      next_ns     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      elapsed <= elapsed_nxt;
`ifdef TLC_PED_EN
      ped_pending <= ped_pending_nxt;
      next_ns     <= next_ns_nxt;
`endif
    end
  end

  always_comb begin
    cur_dur  = ALLRED_D;
    advance  = ALL_RED_2;
    illegal  = 1'b0;
    ns_light = RED;
    ew_light = RED;
    case (state)
      NS_GREEN:  begin cur_dur = GREEN_D;  advance = NS_YELLOW; ns_light = GREEN;  end
      NS_YELLOW: begin cur_dur = YELLOW_D; advance = ALL_RED_1; ns_light = YELLOW; end
      ALL_RED_1: begin cur_dur = ALLRED_D; advance = EW_GREEN; end
      EW_GREEN:  begin cur_dur = GREEN_D;  advance = EW_YELLOW; ew_light = GREEN;  end
      EW_YELLOW: begin cur_dur = YELLOW_D; advance = ALL_RED_2; ew_light = YELLOW; end
      ALL_RED_2: begin cur_dur = ALLRED_D; advance = NS_GREEN; end
`ifdef TLC_PED_EN
      PED_WALK:  begin cur_dur = WALK_D;   advance = next_ns ? NS_GREEN : EW_GREEN; end
`endif
      default:   illegal = 1'b1;
    endcase

`ifdef TLC_PED_EN
    // A pending request diverts either all-red exit into the walk phase.
    if (ped_pending && (state == ALL_RED_1 || state == ALL_RED_2))
      advance = PED_WALK;
`endif

    state_nxt   = state;
    elapsed_nxt = elapsed;
    if (illegal) begin
      state_nxt   = ALL_RED_2;
      elapsed_nxt = '0;
    end else if (tick) begin
      if (elapsed == cur_dur - 1'b1) begin
        state_nxt   = advance;
        elapsed_nxt = '0;
      end else begin
        elapsed_nxt = elapsed + 1'b1;
      end
    end

`ifdef TLC_PED_EN
    enter_walk      = !illegal && tick && (elapsed == cur_dur - 1'b1) && (advance == PED_WALK);
    ped_pending_nxt = ped_req | (ped_pending & ~enter_walk);
    next_ns_nxt     = enter_walk ? (state == ALL_RED_2) : next_ns;
`endif
  end

  assign phase_remaining = cur_dur - elapsed;

`ifdef TLC_PED_EN
  assign walk = (state == PED_WALK);
`else
  assign walk = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Randomized self-checking bench for traffic_light_fsm against a phase-table model.
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] ten_sec;
  logic       ped_req;
  logic       ped_hold;
  logic [2:0] ns_light, ew_light;
  logic       walk;
  logic [6:0] phase_remaining;

  int checks   = 0;
  int failures = 0;
  int walk_cnt = 0;

`ifdef TLC_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  // Phase table: 0 NS green, 1 NS yellow, 2 red, 3 EW green, 4 EW yellow, 5 red, 6 walk
  int t_ns  [7] = '{1, 2, 4, 4, 4, 4, 4};
  int t_ew  [7] = '{4, 4, 4, 1, 2, 4, 4};
  int t_wk  [7] = '{0, 0, 0, 0, 0, 0, 1};
  int t_dur [7] = '{5, 2, 1, 5, 2, 1, 3};

  int m_phase, m_elapsed;
  bit m_pending, m_next_ns;

  traffic_light_fsm #(
    .GREEN_T  (5),
    .YELLOW_T (2),
    .ALLRED_T (1),
    .WALK_T   (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ten_sec         (ten_sec),
    .ped_req         (ped_req),
    .ns_light        (ns_light),
    .ew_light        (ew_light),
    .walk            (walk),
    .phase_remaining (phase_remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_pending = 0; m_next_ns = 0;
  endtask

  task automatic model_tick();
    m_elapsed++;
    if (m_elapsed == t_dur[m_phase]) begin
      m_elapsed = 0;
      if (PED_EN && m_pending && (m_phase == 2 || m_phase == 5)) begin
        m_next_ns = (m_phase == 5);
        m_pending = 0;
        m_phase   = 6;
      end else if (m_phase == 6) begin
        m_phase = m_next_ns ? 0 : 3;
      end else begin
        m_phase = (m_phase + 1) % 6;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ns"},   ns_light, t_ns[m_phase]);
    check({tag, ".ew"},   ew_light, t_ew[m_phase]);
    check({tag, ".walk"}, walk,     t_wk[m_phase]);
    check({tag, ".rem"},  phase_remaining, t_dur[m_phase] - m_elapsed);
    check({tag, ".dual_green"}, int'(ns_light == 3'b001 && ew_light == 3'b001), 0);
  endtask

  task automatic step(input string tag, input logic [6:0] v, input bit pulse);
    bit chg;
    @(negedge clk);
    chg = (v != ten_sec);
    ten_sec = v;
    repeat (8) @(negedge clk);
    if (pulse) begin
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = ped_hold;
    end
    if (chg) model_tick();
    if (pulse) m_pending = 1'b1;
    repeat (10) @(negedge clk);
    check_all(tag);
    if (walk) walk_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    ten_sec = '0;
    ped_req = ped_hold;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [6:0] v;
    int guard;
    reset = 1'b0; ten_sec = '0; ped_hold = 1'b0; ped_req = 1'b0;
    model_reset();
    #23;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (500) @(negedge clk);
    check_all("hold_const");

    for (int i = 1; i <= 4; i++) step("ns_green", 7'(i), 1'b0);
    @(negedge clk);
    ten_sec = 7'd5;
    @(posedge clk); #1;
    check("edge_n.ns", ns_light, 1);
    @(posedge clk); #1;
    check("edge_n1.ns", ns_light, 2);
    model_tick();
    repeat (18) @(negedge clk);
    check_all("ns_yellow");

    for (int i = 6; i <= 15; i++) step("cycle", 7'(i), 1'b0);
    step("cycle16", 7'd97, 1'b0);
    check("cycle16.phase", ns_light, 1);
    step("wrap98", 7'd98, 1'b0);
    step("wrap99", 7'd99, 1'b0);
    step("wrap0",  7'd0,  1'b0);
    step("wrap1",  7'd1,  1'b0);
    check("wrap.rem", phase_remaining, 1);

`ifdef TLC_PED_EN
    do_reset();
    walk_cnt = 0;
    step("ped", 7'd1, 1'b1);
    for (int i = 2; i <= 12; i++) step("ped", 7'(i), 1'b0);
    check("ped.walk_ticks", walk_cnt, 3);
    check("ped.after_walk", ew_light, 1);
    for (int i = 13; i <= 30; i++) step("ped_none", 7'(i), 1'b0);
    check("ped.no_rewalk", walk_cnt, 3);
`else
    do_reset();
    ped_hold = 1'b1;
    ped_req  = 1'b1;
    walk_cnt = 0;
    for (int i = 1; i <= 16; i++) step("ped_ignored", 7'(i), 1'b0);
    check("ped_ignored.walk", walk_cnt, 0);
    check("ped_ignored.cycle", ns_light, 1);
    ped_hold = 1'b0;
    ped_req  = 1'b0;
`endif

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: v = ten_sec;
        1, 2: v = (ten_sec == 7'd99) ? 7'd0 : ten_sec + 7'd1;
        default: begin
          v = 7'($urandom_range(0, 99));
          if (v == ten_sec) v = (ten_sec == 7'd99) ? 7'd0 : ten_sec + 7'd1;
        end
      endcase
      step("rand", v, ($urandom_range(0, 3) == 0));
    end

    do_reset();
    guard = 0;
    while (m_phase != 4 && guard < 20) begin
      step("to_ew_yellow", (ten_sec == 7'd99) ? 7'd0 : ten_sec + 7'd1, 1'b0);
      guard++;
    end
    check("reach_ew_yellow", m_phase, 4);
    step("ew_yellow_pulse", ten_sec, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    ten_sec = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    walk_cnt = 0;
    for (int i = 1; i <= 16; i++) step("restart", 7'(i), 1'b0);
    check("restart.no_walk", walk_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
